// File: rtl/spi_data_path.sv
// rtl/spi_data_path.sv - SPI MOSI/MISO serialisation beside spi_cu: TX FIFO, shift registers, RX hand-off
module spi_data_path #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_wr_i,
    output logic              tx_full_o,
    output logic              tx_empty_o,
    output logic              tx_ovf_o,
    output logic              start_tx_o,
    input  logic              load_tx_i,
    input  logic              shift_tx_i,
    input  logic              shift_rx_i,
    input  logic              end_tx_i,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_rd_i,
    output logic              rx_ovf_o,
    output logic              rx_short_o,
    output logic              busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BITS  = CNT_W'(DATA_W);
    localparam logic [PTR_W:0]   DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                tx_ovf_q, tx_ovf_d;
    logic                start_q, start_d;
    logic                mosi_q, mosi_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_ovf_q, rx_ovf_d;
    logic                rx_short_q, rx_short_d;
    logic                load_q, shtx_q, shrx_q, end_q;
    logic                load_rise, shtx_rise, shrx_rise, end_rise;
    logic                push, pop, full, empty;
    logic [DATA_W-1:0]   head;

    // spi_cu strobes are levels; only their rising edges carry meaning
    assign load_rise = load_tx_i  & ~load_q;
    assign shtx_rise = shift_tx_i & ~shtx_q;
    assign shrx_rise = shift_rx_i & ~shrx_q;
    assign end_rise  = end_tx_i   & ~end_q;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign push  = tx_wr_i & (~full | pop);

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        mosi_d     = mosi_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_rd_i;
        rx_short_d = rx_short_q;
        rx_ovf_d   = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                mosi_d  = 1'b0;
                start_d = 1'b0;
                if (!empty) begin
                    state_d = REQ;
                    start_d = 1'b1;
                end
            end
            REQ: begin
                start_d = 1'b1;
                if (load_rise) begin
                    pop      = 1'b1;
                    tx_sr_d  = head;
                    mosi_d   = (MSB_FIRST != 0) ? head[DATA_W-1] : head[0];
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    rx_sr_d  = '0;
                    start_d  = 1'b0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (shtx_rise) begin
                    if (MSB_FIRST != 0) begin
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        mosi_d  = tx_sr_q[DATA_W-2];
                    end else begin
                        tx_sr_d = {1'b0, tx_sr_q[DATA_W-1:1]};
                        mosi_d  = tx_sr_q[1];
                    end
                    if (tx_cnt_q != BITS) tx_cnt_d = tx_cnt_q + 1'b1;
                end
                if (shrx_rise) begin
                    if (MSB_FIRST != 0) rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_i};
                    else                rx_sr_d = {miso_i, rx_sr_q[DATA_W-1:1]};
                    if (rx_cnt_q != BITS) rx_cnt_d = rx_cnt_q + 1'b1;
                end
                if (end_rise) state_d = DONE;
            end
            DONE: begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
                rx_short_d = (rx_cnt_q != BITS);
                rx_ovf_d   = rx_valid_q & ~rx_rd_i;
                mosi_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        tx_ovf_d = tx_wr_i & ~push;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_ovf_q   <= 1'b0;
            start_q    <= 1'b0;
            mosi_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_short_q <= 1'b0;
            load_q     <= 1'b0;
            shtx_q     <= 1'b0;
            shrx_q     <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_ovf_q   <= tx_ovf_d;
            start_q    <= start_d;
            mosi_q     <= mosi_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_short_q <= rx_short_d;
            load_q     <= load_tx_i;
            shtx_q     <= shift_tx_i;
            shrx_q     <= shift_rx_i;
            end_q      <= end_tx_i;
        end
    end

    assign tx_full_o  = full;
    assign tx_empty_o = empty;
    assign tx_ovf_o   = tx_ovf_q;
    assign start_tx_o = start_q;
    assign mosi_o     = mosi_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_ovf_o   = rx_ovf_q;
    assign rx_short_o = rx_short_q;
    assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_data_path.sv
// tb/tb_spi_data_path.sv - bench driving an MSB-first and an LSB-first instance with one spi_cu model
module tb_spi_data_path;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_wr = 0, load = 0, shtx = 0, shrx = 0, endtx = 0, miso = 0, rx_rd = 0;

    logic       a_full, a_empty, a_txovf, a_start, a_mosi, a_valid, a_rxovf, a_short, a_busy;
    logic       b_full, b_empty, b_txovf, b_start, b_mosi, b_valid, b_rxovf, b_short, b_busy;
    logic [7:0] a_rxdata, b_rxdata;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    bit         m_valid = 0;

    always #5 clk = ~clk;

    spi_data_path #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_msb (
        .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data), .tx_wr_i(tx_wr),
        .tx_full_o(a_full), .tx_empty_o(a_empty), .tx_ovf_o(a_txovf), .start_tx_o(a_start),
        .load_tx_i(load), .shift_tx_i(shtx), .shift_rx_i(shrx), .end_tx_i(endtx),
        .miso_i(miso), .mosi_o(a_mosi), .rx_data_o(a_rxdata), .rx_valid_o(a_valid),
        .rx_rd_i(rx_rd), .rx_ovf_o(a_rxovf), .rx_short_o(a_short), .busy_o(a_busy));

    spi_data_path #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
        .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data), .tx_wr_i(tx_wr),
        .tx_full_o(b_full), .tx_empty_o(b_empty), .tx_ovf_o(b_txovf), .start_tx_o(b_start),
        .load_tx_i(load), .shift_tx_i(shtx), .shift_rx_i(shrx), .end_tx_i(endtx),
        .miso_i(miso), .mosi_o(b_mosi), .rx_data_o(b_rxdata), .rx_valid_o(b_valid),
        .rx_rd_i(rx_rd), .rx_ovf_o(b_rxovf), .rx_short_o(b_short), .busy_o(b_busy));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    task automatic write_word(input logic [7:0] d);
        bit acc;
        acc = (q.size() < 4);
        tx_data = d;
        tx_wr = 1'b1;
        tick();
        tx_wr = 1'b0;
        if (acc) q.push_back(d);
        n_cmp++;
        if ({a_txovf, b_txovf, a_full, b_full, a_empty, b_empty} !==
            {{2{!acc}}, {2{q.size() == 4}}, 2'b00}) begin
            n_err++;
            $display("FAIL write_flags: ovf/full/empty got %b%b %b%b %b%b want ovf=%0b full=%0b empty=0",
                     a_txovf, b_txovf, a_full, b_full, a_empty, b_empty, !acc, q.size() == 4);
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!(a_start && b_start) && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if ({a_start, b_start, a_busy, b_busy} !== 4'b1111) begin
            n_err++;
            $display("FAIL wait_start: start=%b%b busy=%b%b want 1111", a_start, b_start, a_busy, b_busy);
        end
    endtask

    // spi_cu model: one transfer of the FIFO head while feeding miso_w MSB-of-stream first
    task automatic xfer(input logic [7:0] miso_w, input int n_rx, input int ld_hold,
                        input int sh_hold, input bit rd_at_done);
        logic [7:0] txw;
        bit exp_ovf;
        txw = q.pop_front();
        wait_start();
        load = 1'b1;
        repeat (ld_hold) tick();
        load = 1'b0;
        tick();
        n_cmp++;
        if ({a_start, b_start, a_busy, b_busy} !== 4'b0011) begin
            n_err++;
            $display("FAIL load: start=%b%b busy=%b%b want 0011", a_start, b_start, a_busy, b_busy);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({a_mosi, b_mosi} !== {txw[7 - i], txw[i]}) begin
                n_err++;
                $display("FAIL mosi_bit%0d: got msb/lsb %b%b want %b%b (word %h)",
                         i, a_mosi, b_mosi, txw[7 - i], txw[i], txw);
            end
            if (i < n_rx) begin
                miso = miso_w[7 - i];
                shrx = 1'b1;
            end
            shtx = (i < 7);
            repeat (sh_hold) tick();
            shrx = 1'b0;
            shtx = 1'b0;
            tick();
        end
        exp_ovf = m_valid && !rd_at_done;
        endtx = 1'b1;
        tick();
        rx_rd = rd_at_done;
        tick();
        endtx = 1'b0;
        rx_rd = 1'b0;
        m_valid = 1;
        n_cmp++;
        if ({a_valid, b_valid, a_short, b_short, a_rxovf, b_rxovf, a_mosi, b_mosi} !==
            {2'b11, {2{n_rx != 8}}, {2{exp_ovf}}, 2'b00}) begin
            n_err++;
            $display("FAIL done_flags: valid=%b%b short=%b%b rxovf=%b%b mosi=%b%b want valid=11 short=%0b rxovf=%0b mosi=00",
                     a_valid, b_valid, a_short, b_short, a_rxovf, b_rxovf, a_mosi, b_mosi, n_rx != 8, exp_ovf);
        end
        if (n_rx == 8) begin
            n_cmp++;
            if (a_rxdata !== miso_w || b_rxdata !== bitrev(miso_w)) begin
                n_err++;
                $display("FAIL rx_data: got msb=%h lsb=%h want msb=%h lsb=%h",
                         a_rxdata, b_rxdata, miso_w, bitrev(miso_w));
            end
        end
        tick();
        n_cmp++;
        if ({a_rxovf, b_rxovf, a_valid, b_valid} !== 4'b0011) begin
            n_err++;
            $display("FAIL rxovf_pulse: rxovf=%b%b valid=%b%b want 0011", a_rxovf, b_rxovf, a_valid, b_valid);
        end
    endtask

    task automatic read_word();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        m_valid = 0;
        n_cmp++;
        if ({a_valid, b_valid, a_rxovf, b_rxovf} !== 4'b0000) begin
            n_err++;
            $display("FAIL read: valid=%b%b rxovf=%b%b want 0000", a_valid, b_valid, a_rxovf, b_rxovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({a_full, a_empty, a_txovf, a_start, a_mosi, a_rxdata, a_valid, a_rxovf, a_short, a_busy,
             b_full, b_empty, b_txovf, b_start, b_mosi, b_rxdata, b_valid, b_rxovf, b_short, b_busy} !==
            {2'b01, 3'b000, 8'h00, 4'b0000, 2'b01, 3'b000, 8'h00, 4'b0000}) begin
            n_err++;
            $display("FAIL reset: msb full=%b empty=%b ovf=%b start=%b mosi=%b rx=%h v=%b o=%b s=%b busy=%b want empty=1 rest 0",
                     a_full, a_empty, a_txovf, a_start, a_mosi, a_rxdata, a_valid, a_rxovf, a_short, a_busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        write_word(8'hA5);
        n_cmp++;
        if ({a_start, b_start} !== 2'b00) begin
            n_err++;
            $display("FAIL latency1: start=%b%b want 00", a_start, b_start);
        end
        tick();
        n_cmp++;
        if ({a_start, b_start, a_busy, b_busy} !== 4'b1111) begin
            n_err++;
            $display("FAIL latency2: start=%b%b busy=%b%b want 1111", a_start, b_start, a_busy, b_busy);
        end
        xfer(8'h3C, 8, 1, 1, 0);
        read_word();
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            write_word(8'($urandom));
            xfer(8'($urandom), 8, $urandom_range(1, 3), $urandom_range(1, 3), 0);
            read_word();
        end
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < 5; k++) write_word(8'($urandom));
        tick();
        n_cmp++;
        if ({a_txovf, b_txovf, a_full, b_full} !== 4'b0011) begin
            n_err++;
            $display("FAIL txovf_pulse: txovf=%b%b full=%b%b want 0011", a_txovf, b_txovf, a_full, b_full);
        end
        for (int k = 0; k < 4; k++) begin
            xfer(8'($urandom), 8, 1, 1, 0);
            read_word();
        end
        n_cmp++;
        if ({a_empty, b_empty} !== 2'b11) begin
            n_err++;
            $display("FAIL drained: empty=%b%b want 11", a_empty, b_empty);
        end
    endtask

    task automatic test_back_to_back();
        write_word(8'($urandom));
        write_word(8'($urandom));
        xfer(8'($urandom), 8, 1, 1, 0);
        write_word(8'($urandom));
        xfer(8'($urandom), 8, 2, 1, 0);
        xfer(8'($urandom), 8, 1, 2, 1);
        read_word();
    endtask

    task automatic test_hold_and_short();
        write_word(8'($urandom));
        xfer(8'($urandom), 8, 5, 3, 0);
        read_word();
        write_word(8'hA5);
        xfer(8'($urandom), 5, 1, 1, 0);
        read_word();
    endtask

    task automatic test_ignored_edges();
        load = 1'b1; tick(); load = 1'b0;
        shtx = 1'b1; shrx = 1'b1; tick(); shtx = 1'b0; shrx = 1'b0;
        endtx = 1'b1; tick(); endtx = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({a_busy, b_busy, a_valid, b_valid, a_empty, b_empty, a_mosi, b_mosi} !== 8'b00001100) begin
            n_err++;
            $display("FAIL ignored: busy=%b%b valid=%b%b empty=%b%b mosi=%b%b want 00 00 11 00",
                     a_busy, b_busy, a_valid, b_valid, a_empty, b_empty, a_mosi, b_mosi);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) write_word(8'hFF);
        wait_start();
        load = 1'b1; tick(); load = 1'b0; tick();
        shtx = 1'b1; tick(); shtx = 1'b0; tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({a_busy, b_busy, a_empty, b_empty, a_mosi, b_mosi, a_start, b_start} !== 8'b00110000) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b%b empty=%b%b mosi=%b%b start=%b%b want 00 11 00 00",
                     a_busy, b_busy, a_empty, b_empty, a_mosi, b_mosi, a_start, b_start);
        end
        rst_n = 1'b1;
        q.delete();
        m_valid = 0;
        tick();
        tick();
        n_cmp++;
        if ({a_busy, b_busy, a_start, b_start} !== 4'b0000) begin
            n_err++;
            $display("FAIL after_reset: busy=%b%b start=%b%b want 0000", a_busy, b_busy, a_start, b_start);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_fifo_full();
        test_back_to_back();
        test_hold_and_short();
        test_ignored_edges();
        test_reset_mid();
        write_word(8'h5A);
        xfer(8'($urandom), 8, 1, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
